// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Serial program loader that sits in front of the CPU instruction fetch port.
// It receives a framed byte stream, writes the payload into an internal
// 2^ADDR_W x 8 program memory and then serves that memory as the CPU's
// instruction ROM. The CPU is held in reset until a complete, valid frame
// has been loaded.
//
// Frame: SYNC_BYTE, length N (1..255), N payload bytes, [checksum byte].
// The checksum byte makes the 8-bit sum of payload + checksum equal zero.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   defined   -> CHK state and running-sum register exist; a frame carries a
//                trailing checksum byte.
//   undefined -> no CHK state, no sum register; the last payload byte moves
//                LOAD straight to RUN.
//
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous active-high reset
//   rx_data       in   8       incoming frame byte
//   rx_valid      in   1       rx_data valid
//   rx_ready      out  1       loader can accept a byte
//   restart       in   1       synchronous reload request (RUN/ERROR only)
//   ler_endereco  in   ADDR_W  instruction fetch address (CPU PC)
//   instrucao_out out  8       instruction at ler_endereco (combinational)
//   cpu_reset     out  1       CPU reset, high in every state except RUN
//   load_done     out  1       high in RUN
//   load_error    out  1       high in ERROR
//   state_dbg     out  3       raw FSM state encoding, for observation only
//
// Handshake: a byte is transferred on a rising edge where rx_valid && rx_ready
// are both high. rx_valid may drop at any time; a cycle without the transfer
// leaves all loader state untouched. rx_ready does not depend on rx_valid.
// -----------------------------------------------------------------------------
module boot_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    input  logic [ADDR_W-1:0] ler_endereco,
    output logic [7:0]        instrucao_out,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [2:0]        state_dbg
);

    // The loaded-byte counter must hold any N up to 255 and also cover the
    // whole address range, so it is at least 8 bits wide.
    localparam int CW = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        ST_CHK   = 3'd3,
`endif
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t            state_q, state_n;
    logic [7:0]        len_q, len_n;
    logic [CW-1:0]     loaded_cnt, loaded_cnt_n;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_n;
`endif

    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW-1:0]     cnt_inc;

    logic [7:0]        mem [2**ADDR_W];

    // ------------------------------------------------------------------
    // Output decode: everything CPU-facing comes straight from the state
    // register so it changes one cycle after the deciding byte.
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready   = (state_q != ST_RUN) && (state_q != ST_ERROR);
        cpu_reset  = (state_q != ST_RUN);
        load_done  = (state_q == ST_RUN);
        load_error = (state_q == ST_ERROR);
        state_dbg  = state_q;
    end

    assign accept  = rx_valid && rx_ready;
    assign cnt_inc = loaded_cnt + CW'(1);
    assign wr_addr = ADDR_W'(loaded_cnt);

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state_q;
        len_n        = len_q;
        loaded_cnt_n = loaded_cnt;
        mem_we       = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_n        = sum_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Anything that is not the sync marker is silently dropped.
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_n = ST_LEN;
                end
            end

            ST_LEN: begin
                if (accept) begin
                    loaded_cnt_n = '0;
                    if (rx_data == 8'h00) begin
                        state_n = ST_ERROR;
                    end else begin
                        len_n   = rx_data;
                        state_n = ST_LOAD;
`ifdef BOOT_CHECKSUM_EN
                        sum_n   = 8'h00;
`endif
                    end
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    mem_we       = 1'b1;
                    loaded_cnt_n = cnt_inc;
`ifdef BOOT_CHECKSUM_EN
                    sum_n        = sum_q + rx_data;
`endif
                    if (cnt_inc == CW'(len_q)) begin
`ifdef BOOT_CHECKSUM_EN
                        state_n = ST_CHK;
`else
                        state_n = ST_RUN;
`endif
                    end
                end
            end

`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if ((sum_q + rx_data) == 8'h00) begin
                        state_n = ST_RUN;
                    end else begin
                        // Hide the rejected payload from the fetch port.
                        state_n      = ST_ERROR;
                        loaded_cnt_n = '0;
                    end
                end
            end
`endif

            ST_RUN, ST_ERROR: begin
                if (restart) begin
                    state_n      = ST_IDLE;
                    loaded_cnt_n = '0;
                end
            end

            default: begin
                state_n      = ST_IDLE;
                loaded_cnt_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'h00;
            loaded_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_n;
            len_q      <= len_n;
            loaded_cnt <= loaded_cnt_n;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= sum_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Program memory. Contents are never reset; loaded_cnt alone decides
    // which locations are visible, so stale data always reads as 8'h00.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= rx_data;
        end
    end

    always_comb begin
        if (CW'(ler_endereco) < loaded_cnt) begin
            instrucao_out = mem[ler_endereco];
        end else begin
            instrucao_out = 8'h00;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Directed, table-driven bench for boot_loader. Each step record carries the
// stimulus for one clock cycle and the expected {cpu_reset, load_done,
// load_error, rx_ready} after that edge; read records carry a fetch address
// and the expected instruction byte. Frames include the checksum byte only
// when BOOT_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       restart;
    logic [7:0] ler_endereco;
    logic [7:0] instrucao_out;
    logic       cpu_reset;
    logic       load_done;
    logic       load_error;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // {cpu_reset, load_done, load_error, rx_ready}
    localparam logic [3:0] O_LD  = 4'b1001;
    localparam logic [3:0] O_RUN = 4'b0100;
    localparam logic [3:0] O_ERR = 4'b1010;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       rst_req;
        logic [3:0] exp;
    } step_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_t;

    step_t steps[$];
    rd_t   reads[$];

    boot_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .restart       (restart),
        .ler_endereco  (ler_endereco),
        .instrucao_out (instrucao_out),
        .cpu_reset     (cpu_reset),
        .load_done     (load_done),
        .load_error    (load_error),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- table builders ----------------
    function automatic void add(input logic v, input logic [7:0] d,
                                input logic r, input logic [3:0] e);
        step_t s;
        s.valid   = v;
        s.data    = d;
        s.rst_req = r;
        s.exp     = e;
        steps.push_back(s);
    endfunction

    function automatic void add_rd(input logic [7:0] a, input logic [7:0] e);
        rd_t r;
        r.addr = a;
        r.exp  = e;
        reads.push_back(r);
    endfunction

    // A5 03 11 22 33 [9A]: 0x11+0x22+0x33 = 0x66, 0x66+0x9A = 0x100.
    function automatic void add_good_frame();
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h03, 1'b0, O_LD);
        add(1'b1, 8'h11, 1'b0, O_LD);
        add(1'b1, 8'h22, 1'b0, O_LD);
`ifdef BOOT_CHECKSUM_EN
        add(1'b1, 8'h33, 1'b0, O_LD);
        add(1'b1, 8'h9A, 1'b0, O_RUN);
`else
        add(1'b1, 8'h33, 1'b0, O_RUN);
`endif
    endfunction

    function automatic void add_good_reads();
        add_rd(8'h00, 8'h11);
        add_rd(8'h01, 8'h22);
        add_rd(8'h02, 8'h33);
        add_rd(8'h03, 8'h00);
        add_rd(8'hFF, 8'h00);
    endfunction

    // ---------------- checkers ----------------
    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {cpu_reset, load_done, load_error, rx_ready};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s {cpu_reset,load_done,load_error,rx_ready} actual=%04b expected=%04b",
                     name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic run_steps(input string tag);
        for (int i = 0; i < steps.size(); i++) begin
            rx_valid = steps[i].valid;
            rx_data  = steps[i].data;
            restart  = steps[i].rst_req;
            @(posedge clk);
            #1;
            check_outs($sformatf("%s step%0d", tag, i), steps[i].exp);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        steps.delete();
    endtask

    task automatic run_reads(input string tag);
        for (int i = 0; i < reads.size(); i++) begin
            @(negedge clk);
            ler_endereco = reads[i].addr;
            #1;
            check8($sformatf("%s read@%02h", tag, reads[i].addr),
                   instrucao_out, reads[i].exp);
        end
        reads.delete();
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            ler_endereco = 8'(a);
            #1;
            check8($sformatf("%s read@%02h", tag, a), instrucao_out, 8'h00);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        restart      = 1'b0;
        ler_endereco = 8'h00;
        #1;
        check_outs("reset outputs", O_LD);
        sweep_zero("reset");
        check_outs("reset outputs after sweep", O_LD);
        @(negedge clk);
        reset = 1'b0;

        // Valid frame, back to back.
        add_good_frame();
        run_steps("good");
        add_good_reads();
        run_reads("good");

        // RUN accepts no bytes; memory view is unchanged.
        add(1'b1, 8'hA5, 1'b0, O_RUN);
        add(1'b1, 8'h01, 1'b0, O_RUN);
        run_steps("run_ignore");
        add_good_reads();
        run_reads("run_ignore");

        // restart clears visibility.
        add(1'b0, 8'h00, 1'b1, O_LD);
        run_steps("restart1");
        add_rd(8'h00, 8'h00);
        add_rd(8'h02, 8'h00);
        run_reads("restart1");

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum -> ERROR; then restart (with a byte offered) and reload.
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h03, 1'b0, O_LD);
        add(1'b1, 8'h11, 1'b0, O_LD);
        add(1'b1, 8'h22, 1'b0, O_LD);
        add(1'b1, 8'h33, 1'b0, O_LD);
        add(1'b1, 8'h9B, 1'b0, O_ERR);
        add(1'b1, 8'hA5, 1'b0, O_ERR);
        run_steps("badchk");
        add_rd(8'h00, 8'h00);
        add_rd(8'h01, 8'h00);
        add_rd(8'h02, 8'h00);
        add_rd(8'hFF, 8'h00);
        run_reads("badchk");
        add(1'b1, 8'hA5, 1'b1, O_LD);
        add_good_frame();
        run_steps("badchk_reload");
        add_good_reads();
        run_reads("badchk_reload");
        add(1'b0, 8'h00, 1'b1, O_LD);
        run_steps("restart2");
`endif

        // Junk before sync, then zero length -> ERROR.
        add(1'b1, 8'h00, 1'b0, O_LD);
        add(1'b1, 8'h7F, 1'b0, O_LD);
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h00, 1'b0, O_ERR);
        add(1'b0, 8'h00, 1'b0, O_ERR);
        run_steps("zero_len");
        add_rd(8'h00, 8'h00);
        run_reads("zero_len");

        // Recover, junk, then a valid frame.
        add(1'b0, 8'h00, 1'b1, O_LD);
        add(1'b1, 8'h00, 1'b0, O_LD);
        add(1'b1, 8'h7F, 1'b0, O_LD);
        run_steps("junk");
        add_good_frame();
        run_steps("junk_frame");
        add_good_reads();
        run_reads("junk_frame");

        // rx_valid toggling every other cycle; gap data is garbage.
        add(1'b0, 8'h00, 1'b1, O_LD);
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b0, 8'hFF, 1'b0, O_LD);
        add(1'b1, 8'h03, 1'b0, O_LD);
        add(1'b0, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h11, 1'b0, O_LD);
        add(1'b0, 8'h77, 1'b0, O_LD);
        add(1'b1, 8'h22, 1'b0, O_LD);
        add(1'b0, 8'h00, 1'b0, O_LD);
`ifdef BOOT_CHECKSUM_EN
        add(1'b1, 8'h33, 1'b0, O_LD);
        add(1'b0, 8'h9B, 1'b0, O_LD);
        add(1'b1, 8'h9A, 1'b0, O_RUN);
`else
        add(1'b1, 8'h33, 1'b0, O_RUN);
`endif
        add(1'b0, 8'h00, 1'b0, O_RUN);
        run_steps("gappy");
        add_good_reads();
        run_reads("gappy");

        // Reset after 2 of 3 payload bytes.
        add(1'b0, 8'h00, 1'b1, O_LD);
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h03, 1'b0, O_LD);
        add(1'b1, 8'h11, 1'b0, O_LD);
        add(1'b1, 8'h22, 1'b0, O_LD);
        run_steps("midframe");
        ler_endereco = 8'h00;
        reset = 1'b1;
        #1;
        check_outs("midframe reset outputs", O_LD);
        check8("midframe reset read@00", instrucao_out, 8'h00);
        add_rd(8'h01, 8'h00);
        add_rd(8'h02, 8'h00);
        run_reads("midframe_rst");
        @(negedge clk);
        reset = 1'b0;
        // A5 03 55 66 77 [CE]: 0x55+0x66+0x77 = 0x132 -> 0x32, 0x32+0xCE = 0x100.
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h03, 1'b0, O_LD);
        add(1'b1, 8'h55, 1'b0, O_LD);
        add(1'b1, 8'h66, 1'b0, O_LD);
`ifdef BOOT_CHECKSUM_EN
        add(1'b1, 8'h77, 1'b0, O_LD);
        add(1'b1, 8'hCE, 1'b0, O_RUN);
`else
        add(1'b1, 8'h77, 1'b0, O_RUN);
`endif
        run_steps("after_rst");
        add_rd(8'h00, 8'h55);
        add_rd(8'h01, 8'h66);
        add_rd(8'h02, 8'h77);
        add_rd(8'h03, 8'h00);
        run_reads("after_rst");

        // Reload a shorter program: stale bytes above it read as 00.
        add(1'b0, 8'h00, 1'b1, O_LD);
        add(1'b1, 8'hA5, 1'b0, O_LD);
        add(1'b1, 8'h01, 1'b0, O_LD);
`ifdef BOOT_CHECKSUM_EN
        add(1'b1, 8'h44, 1'b0, O_LD);
        add(1'b1, 8'hBC, 1'b0, O_RUN);
`else
        add(1'b1, 8'h44, 1'b0, O_RUN);
`endif
        run_steps("short");
        add_rd(8'h00, 8'h44);
        add_rd(8'h01, 8'h00);
        add_rd(8'h02, 8'h00);
        run_reads("short");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
